// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline (IF/MEM stages), the byte-wide RAM and mem_port_arbiter.
// The arbiter uses the slave modport; the pipeline/RAM side uses master.
interface mem_port_arbiter_if;
  logic        flush;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_done;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_len;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic [31:0] ram_addr;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din;

  modport slave (
    input  flush, if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
    output if_data, if_done, mem_rdata, mem_done, ram_addr, ram_dout, ram_wr
  );

  modport master (
    output flush, if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
    input  if_data, if_done, mem_rdata, mem_done, ram_addr, ram_dout, ram_wr
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide RAM port between fetch and data accesses, serialising 8/16/32-bit transfers.
// Optional macro MEM_ARB_RR_EN: round-robin tie-break in IDLE instead of fixed data priority.
module mem_port_arbiter (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus_io
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  state_e      state_q;
  logic        owner_q;
  logic        we_q;
  logic [2:0]  n_q;
  logic [2:0]  k_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] buf_q;
  logic [31:0] if_data_q;
  logic [31:0] mem_rdata_q;
  logic [31:0] ram_addr_q;
  logic [7:0]  ram_dout_q;
  logic        ram_wr_q;
  logic        if_done_q;
  logic        mem_done_q;
`ifdef MEM_ARB_RR_EN
  logic        rr_last_q;
`endif

  logic        fetch_pend_s;
  logic        data_pend_s;
  logic        grant_s;
  logic        grant_data_s;
  logic [31:0] grant_addr_s;
  logic [2:0]  k_d;
  logic [31:0] next_addr_s;
  logic [31:0] buf_d;

  function automatic logic [2:0] len_to_n(input logic [1:0] len);
    case (len)
      2'd0:    len_to_n = 3'd1;
      2'd1:    len_to_n = 3'd2;
      default: len_to_n = 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [2:0] idx);
    case (idx)
      3'd1:    byte_sel = w[15:8];
      3'd2:    byte_sel = w[23:16];
      3'd3:    byte_sel = w[31:24];
      default: byte_sel = w[7:0];
    endcase
  endfunction

  // A flush hides the fetch request from the grant so a stale PC is never started.
  always_comb begin
    fetch_pend_s = bus_io.if_req & ~bus_io.flush;
    data_pend_s  = bus_io.mem_req;
`ifdef MEM_ARB_RR_EN
    if (fetch_pend_s && data_pend_s) begin
      grant_data_s = (rr_last_q == OWN_FETCH);
    end else begin
      grant_data_s = data_pend_s;
    end
`else
    grant_data_s = data_pend_s;
`endif
    grant_s      = fetch_pend_s | data_pend_s;
    grant_addr_s = grant_data_s ? bus_io.mem_addr : bus_io.if_addr;
  end

  // Read byte k-1 arrives on ram_din while k_q==k, one cycle behind its address.
  always_comb begin
    k_d         = k_q + 3'd1;
    next_addr_s = addr_q + {29'd0, k_d};
    buf_d       = buf_q;
    case (k_q)
      3'd1:    buf_d[7:0]   = bus_io.ram_din;
      3'd2:    buf_d[15:8]  = bus_io.ram_din;
      3'd3:    buf_d[23:16] = bus_io.ram_din;
      3'd4:    buf_d[31:24] = bus_io.ram_din;
      default: buf_d        = buf_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_FETCH;
      we_q        <= 1'b0;
      n_q         <= 3'd0;
      k_q         <= 3'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      buf_q       <= 32'd0;
      if_data_q   <= 32'd0;
      mem_rdata_q <= 32'd0;
      ram_addr_q  <= 32'd0;
      ram_dout_q  <= 8'd0;
      ram_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
`ifdef MEM_ARB_RR_EN
      rr_last_q   <= OWN_FETCH;
`endif
    end else begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      ram_wr_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_s) begin
            state_q    <= RUN;
            owner_q    <= grant_data_s ? OWN_DATA : OWN_FETCH;
            we_q       <= grant_data_s & bus_io.mem_we;
            n_q        <= grant_data_s ? len_to_n(bus_io.mem_len) : 3'd4;
            k_q        <= 3'd0;
            addr_q     <= grant_addr_s;
            wdata_q    <= bus_io.mem_wdata;
            buf_q      <= 32'd0;
            ram_addr_q <= grant_addr_s;
            if (grant_data_s && bus_io.mem_we) begin
              ram_wr_q   <= 1'b1;
              ram_dout_q <= bus_io.mem_wdata[7:0];
            end
`ifdef MEM_ARB_RR_EN
            rr_last_q  <= grant_data_s ? OWN_DATA : OWN_FETCH;
`endif
          end
        end
        RUN: begin
          if (owner_q == OWN_FETCH && bus_io.flush) begin
            state_q <= IDLE;
          end else if (we_q) begin
            if (k_q == n_q - 3'd1) begin
              state_q     <= DONE;
              mem_done_q  <= 1'b1;
              mem_rdata_q <= buf_q;
            end else begin
              k_q        <= k_d;
              ram_addr_q <= next_addr_s;
              ram_dout_q <= byte_sel(wdata_q, k_d);
              ram_wr_q   <= 1'b1;
            end
          end else begin
            buf_q <= buf_d;
            if (k_q == n_q) begin
              state_q <= DONE;
              if (owner_q == OWN_FETCH) begin
                if_done_q <= 1'b1;
                if_data_q <= buf_d;
              end else begin
                mem_done_q  <= 1'b1;
                mem_rdata_q <= buf_d;
              end
            end else begin
              k_q <= k_d;
              // The extra capture cycle after the last address keeps ram_addr steady.
              if (k_d != n_q) begin
                ram_addr_q <= next_addr_s;
              end
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus_io.if_data   = if_data_q;
  assign bus_io.if_done   = if_done_q;
  assign bus_io.mem_rdata = mem_rdata_q;
  assign bus_io.mem_done  = mem_done_q;
  assign bus_io.ram_addr  = ram_addr_q;
  assign bus_io.ram_dout  = ram_dout_q;
  assign bus_io.ram_wr    = ram_wr_q;
endmodule
